// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// hilo_muldiv_unit: HI/LO registers with a shared one-bit-per-cycle mul/div engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               res_neg;
   logic               rem_neg;
   logic               div_zero;

   logic               signed_op;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   assign busy = (state != IDLE);

   // Sign handling happens once at accept and once in FIX; the loop is unsigned.
   assign signed_op = ~op[0];
   assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ok    = ~div_diff[WIDTH];
   assign step_acc  = is_div
                    ? {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ok}
                    : {mul_sum, acc[WIDTH-1:1]};

   // Divide-by-zero leaves |a| as remainder, so the normal sign fix restores hi=a.
   assign prod_fix = res_neg ? -acc : acc;
   assign quo      = acc[WIDTH-1:0];
   assign rem      = acc[2*WIDTH-1:WIDTH];
   assign fix_hi   = is_div ? (rem_neg ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
   assign fix_lo   = is_div ? (div_zero ? {WIDTH{1'b1}} : (res_neg ? -quo : quo))
                            : prod_fix[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !cancel && !op[2]) state_nxt = CALC;
         CALC:    if (cancel) state_nxt = IDLE;
                  else if (cnt == '0) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi       <= '0;
         lo       <= '0;
         dz       <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         res_neg  <= 1'b0;
         rem_neg  <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !cancel) begin
                  if (op == 3'b100) begin
                     hi <= a;
                  end else if (op == 3'b101) begin
                     lo <= a;
                  end else if (!op[2]) begin
                     acc      <= {{WIDTH{1'b0}}, a_mag};
                     opnd     <= b_mag;
                     is_div   <= op[1];
                     res_neg  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                     rem_neg  <= signed_op & op[1] & a[WIDTH-1];
                     div_zero <= (b == '0);
                     cnt      <= CNT_W'(WIDTH - 1);
                  end
               end
            end
            CALC: begin
               if (!cancel) begin
                  acc <= step_acc;
                  if (cnt != '0) cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               if (!cancel) begin
                  hi   <= fix_hi;
                  lo   <= fix_lo;
                  dz   <= is_div & div_zero;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
